instr_fetch_unit: RTL and testbench

- Fetch stage directly downstream of the program counter.
- Takes the current PC and issues one read per instruction to instruction memory over a req/ack handshake.
- Latches the returned word into the instruction register (IR) and presents it to decode with a valid/ready handshake.
- Pulses pc_adv so the PC updates only once per accepted fetch. Handles flush on redirect, misaligned PCs and a memory-timeout watchdog.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/fetch_watchdog.sv | 42 ++++
 rtl/instr_fetch_unit.sv | 182 ++++++++++++++++++
 tb/tb_instr_fetch_unit.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch stage.
//   fetch_state_e : fetch FSM state encoding
//   FLT_*         : fault_code_o values
//   *_MSB/*_LSB   : instruction-register field bit positions
//   is_aligned()  : word-alignment test on a PC
package cpu_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StBusy,
        StHold,
        StDrain,
        StFault
    } fetch_state_e;

    localparam logic [1:0] FLT_NONE     = 2'b00;
    localparam logic [1:0] FLT_MISALIGN = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT  = 2'b10;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned RS_MSB     = 25;
    localparam int unsigned RS_LSB     = 21;
    localparam int unsigned RT_MSB     = 20;
    localparam int unsigned RT_LSB     = 16;
    localparam int unsigned RD_MSB     = 15;
    localparam int unsigned RD_LSB     = 11;
    localparam int unsigned SHAMT_MSB  = 10;
    localparam int unsigned SHAMT_LSB  = 6;
    localparam int unsigned FUNCT_MSB  = 5;
    localparam int unsigned FUNCT_LSB  = 0;
    localparam int unsigned IMM_MSB    = 15;
    localparam int unsigned TARGET_MSB = 25;

    function automatic logic is_aligned(input logic [1:0] pc_lsbs);
        return pc_lsbs == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Memory-response watchdog for the fetch stage.
//   clk_i    : clock
//   rst_n    : asynchronous active-low reset
//   clr_i    : clear the count to zero (has priority over en_i)
//   en_i     : count one waiting cycle
//   expire_o : count has reached Timeout-1
module fetch_watchdog #(
    parameter int unsigned Timeout = 16
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CntW = (Timeout > 2) ? $clog2(Timeout) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(Timeout - 1);

    logic [CntW-1:0] count_q, count_d;

    assign expire_o = (count_q == CntMax);

    // Saturates so it can never wrap back below the expiry value.
    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !expire_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: issues one memory read per PC, captures the word in the
// instruction register and hands it to decode over valid/ready.
//   clk_i, rst_n               : clock, asynchronous active-low reset
//   fetch_en_i, pc_i           : fetch permission and current PC
//   pc_adv_o                   : one-cycle pulse when an instruction is captured
//   flush_i                    : discard held or in-flight instruction
//   mem_req_o/mem_addr_o       : memory read request and address
//   mem_ack_i/mem_rdata_i      : memory response
//   instr_valid_o/instr_ready_i: decode handshake
//   instr_o, instr_pc_o        : IR and the address it came from
//   opcode_o..target_o         : combinational IR fields
//   fault_o, fault_code_o      : sticky fault flag and cause
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              fetch_en_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              pc_adv_o,
    input  logic              flush_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ack_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic [5:0]        opcode_o,
    output logic [4:0]        rs_o,
    output logic [4:0]        rt_o,
    output logic [4:0]        rd_o,
    output logic [4:0]        shamt_o,
    output logic [5:0]        funct_o,
    output logic [15:0]       imm16_o,
    output logic [25:0]       target_o,
    output logic              fault_o,
    output logic [1:0]        fault_code_o
);

    fetch_state_e      state_q;
    logic              mem_req_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic              pc_adv_q;
    logic              instr_valid_q;
    logic [DATA_W-1:0] ir_q;
    logic [ADDR_W-1:0] instr_pc_q;
    logic              fault_q;
    logic [1:0]        fault_code_q;

    logic waiting;
    logic wd_expire;
    logic start_ok;
    logic start_bad;

    // The timer keeps running across BUSY->DRAIN: it is the same outstanding request.
    assign waiting   = (state_q == StBusy) || (state_q == StDrain);
    assign start_ok  = fetch_en_i && is_aligned(pc_i[1:0]);
    assign start_bad = fetch_en_i && !is_aligned(pc_i[1:0]);

    fetch_watchdog #(
        .Timeout (TIMEOUT)
    ) u_watchdog (
        .clk_i    (clk_i),
        .rst_n    (rst_n),
        .clr_i    (!waiting || mem_ack_i),
        .en_i     (waiting && !mem_ack_i),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= '0;
            pc_adv_q      <= 1'b0;
            instr_valid_q <= 1'b0;
            ir_q          <= '0;
            instr_pc_q    <= '0;
            fault_q       <= 1'b0;
            fault_code_q  <= FLT_NONE;
        end else begin
            pc_adv_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start_bad) begin
                        fault_q      <= 1'b1;
                        fault_code_q <= FLT_MISALIGN;
                        state_q      <= StFault;
                    end else if (start_ok) begin
                        mem_addr_q <= pc_i;
                        mem_req_q  <= 1'b1;
                        state_q    <= StBusy;
                    end
                end
                StBusy: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        if (flush_i) begin
                            state_q <= StIdle;
                        end else begin
                            ir_q          <= mem_rdata_i;
                            instr_pc_q    <= mem_addr_q;
                            pc_adv_q      <= 1'b1;
                            instr_valid_q <= 1'b1;
                            state_q       <= StHold;
                        end
                    end else if (wd_expire) begin
                        mem_req_q    <= 1'b0;
                        fault_q      <= 1'b1;
                        fault_code_q <= FLT_TIMEOUT;
                        state_q      <= StFault;
                    end else if (flush_i) begin
                        // Request cannot be withdrawn; wait for the ack and drop it.
                        state_q <= StDrain;
                    end
                end
                StHold: begin
                    if (flush_i) begin
                        instr_valid_q <= 1'b0;
                        state_q       <= StIdle;
                    end else if (instr_ready_i) begin
                        instr_valid_q <= 1'b0;
                        if (start_bad) begin
                            fault_q      <= 1'b1;
                            fault_code_q <= FLT_MISALIGN;
                            state_q      <= StFault;
                        end else if (start_ok) begin
                            mem_addr_q <= pc_i;
                            mem_req_q  <= 1'b1;
                            state_q    <= StBusy;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                end
                StDrain: begin
                    if (mem_ack_i) begin
                        mem_req_q <= 1'b0;
                        state_q   <= StIdle;
                    end else if (wd_expire) begin
                        mem_req_q    <= 1'b0;
                        fault_q      <= 1'b1;
                        fault_code_q <= FLT_TIMEOUT;
                        state_q      <= StFault;
                    end
                end
                StFault: begin
                    mem_req_q     <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign pc_adv_o      = pc_adv_q;
    assign instr_valid_o = instr_valid_q;
    assign instr_o       = ir_q;
    assign instr_pc_o    = instr_pc_q;
    assign fault_o       = fault_q;
    assign fault_code_o  = fault_code_q;

    assign opcode_o = ir_q[OPCODE_MSB:OPCODE_LSB];
    assign rs_o     = ir_q[RS_MSB:RS_LSB];
    assign rt_o     = ir_q[RT_MSB:RT_LSB];
    assign rd_o     = ir_q[RD_MSB:RD_LSB];
    assign shamt_o  = ir_q[SHAMT_MSB:SHAMT_LSB];
    assign funct_o  = ir_q[FUNCT_MSB:FUNCT_LSB];
    assign imm16_o  = ir_q[IMM_MSB:0];
    assign target_o = ir_q[TARGET_MSB:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit.
module tb_instr_fetch_unit;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        fetch_en_i;
    logic [31:0] pc_i;
    logic        pc_adv_o;
    logic        flush_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic [5:0]  opcode_o;
    logic [4:0]  rs_o;
    logic [4:0]  rt_o;
    logic [4:0]  rd_o;
    logic [4:0]  shamt_o;
    logic [5:0]  funct_o;
    logic [15:0] imm16_o;
    logic [25:0] target_o;
    logic        fault_o;
    logic [1:0]  fault_code_o;

    int n_checks = 0;
    int n_errors = 0;
    int adv_cnt  = 0;
    int req_cnt  = 0;
    int base;

    instr_fetch_unit #(
        .ADDR_W  (32),
        .DATA_W  (32),
        .TIMEOUT (16)
    ) dut (
        .clk_i         (clk_i),
        .rst_n         (rst_n),
        .fetch_en_i    (fetch_en_i),
        .pc_i          (pc_i),
        .pc_adv_o      (pc_adv_o),
        .flush_i       (flush_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .opcode_o      (opcode_o),
        .rs_o          (rs_o),
        .rt_o          (rt_o),
        .rd_o          (rd_o),
        .shamt_o       (shamt_o),
        .funct_o       (funct_o),
        .imm16_o       (imm16_o),
        .target_o      (target_o),
        .fault_o       (fault_o),
        .fault_code_o  (fault_code_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        if (pc_adv_o)  adv_cnt <= adv_cnt + 1;
        if (mem_req_o) req_cnt <= req_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; fetch_en_i = 1'b0; pc_i = '0; flush_i = 1'b0;
        mem_ack_i = 1'b0; mem_rdata_i = '0; instr_ready_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk_i);
        #1;
        check("rst_req",   mem_req_o,     0);
        check("rst_addr",  mem_addr_o,    0);
        check("rst_valid", instr_valid_o, 0);
        check("rst_adv",   pc_adv_o,      0);
        check("rst_instr", instr_o,       0);
        check("rst_ipc",   instr_pc_o,    0);
        check("rst_fault", {fault_o, fault_code_o}, 0);
        rst_n = 1'b1;
        tick();

        // Zero-wait memory, back-to-back fetches at 0x00 then 0x04
        base = adv_cnt;
        fetch_en_i = 1'b1; pc_i = 32'h0; mem_ack_i = 1'b1;
        mem_rdata_i = 32'h1234_5678; instr_ready_i = 1'b1;
        tick();
        check("zw_req1",  mem_req_o,  1);
        check("zw_addr1", mem_addr_o, 32'h0);
        pc_i = 32'h4;
        tick();
        check("zw_valid1", instr_valid_o, 1);
        check("zw_instr1", instr_o,       32'h1234_5678);
        check("zw_ipc1",   instr_pc_o,    32'h0);
        check("zw_adv1",   pc_adv_o,      1);
        check("zw_req_off", mem_req_o,    0);
        mem_rdata_i = 32'hAABB_CCDD;
        tick();
        check("zw_req2",   mem_req_o,     1);
        check("zw_addr2",  mem_addr_o,    32'h4);
        check("zw_valid_drop", instr_valid_o, 0);
        check("zw_adv_pulse",  pc_adv_o,  0);
        fetch_en_i = 1'b0;
        tick();
        check("zw_instr2", instr_o,    32'hAABB_CCDD);
        check("zw_ipc2",   instr_pc_o, 32'h4);
        tick();
        check("zw_idle_valid", instr_valid_o, 0);
        check("zw_idle_req",   mem_req_o,     0);
        mem_ack_i = 1'b0; instr_ready_i = 1'b0;
        tick();
        check("zw_adv_count", adv_cnt - base, 2);

        // 3-cycle ack latency, jump instruction
        base = adv_cnt;
        pc_i = 32'h10; fetch_en_i = 1'b1;
        tick();
        fetch_en_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("lat_req",  mem_req_o,  1);
            check("lat_addr", mem_addr_o, 32'h10);
            check("lat_valid", instr_valid_o, 0);
            if (i < 2) tick();
        end
        mem_ack_i = 1'b1; mem_rdata_i = 32'h0800_0005;
        tick();
        mem_ack_i = 1'b0;
        check("lat_valid_hold", instr_valid_o, 1);
        check("lat_target", target_o, 26'h000_0005);
        check("lat_opcode", opcode_o, 6'h02);
        check("lat_imm16",  imm16_o,  16'h0005);
        check("lat_adv",    pc_adv_o, 1);
        tick();
        check("lat_adv_off", pc_adv_o,      0);
        check("lat_still",   instr_valid_o, 1);
        instr_ready_i = 1'b1;
        tick();
        instr_ready_i = 1'b0;
        check("lat_consumed", instr_valid_o, 0);
        check("lat_adv_count", adv_cnt - base, 1);

        // Flush in BUSY cycle 1, ack in cycle 3 -> DRAIN, data dropped
        base = adv_cnt;
        pc_i = 32'h20; fetch_en_i = 1'b1;
        tick();
        fetch_en_i = 1'b0; flush_i = 1'b1;
        check("dr_req_c1", mem_req_o, 1);
        tick();
        check("dr_req_c2",   mem_req_o,     1);
        check("dr_addr_c2",  mem_addr_o,    32'h20);
        check("dr_valid_c2", instr_valid_o, 0);
        tick();
        flush_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'hDEAD_BEEF;
        check("dr_req_c3",  mem_req_o,  1);
        check("dr_addr_c3", mem_addr_o, 32'h20);
        tick();
        mem_ack_i = 1'b0;
        check("dr_req_off", mem_req_o,     0);
        check("dr_valid",   instr_valid_o, 0);
        check("dr_adv",     pc_adv_o,      0);
        check("dr_ir_kept", instr_o,       32'h0800_0005);
        tick();
        check("dr_valid2",    instr_valid_o, 0);
        check("dr_adv_count", adv_cnt - base, 0);
        pc_i = 32'h24; fetch_en_i = 1'b1;
        tick();
        check("dr_next_req",  mem_req_o,  1);
        check("dr_next_addr", mem_addr_o, 32'h24);

        // HOLD with back-pressure, then flush beats instr_ready
        base = adv_cnt;
        fetch_en_i = 1'b0; mem_ack_i = 1'b1; mem_rdata_i = 32'h0022_1820;
        tick();
        mem_ack_i = 1'b0;
        check("hd_rs",    rs_o,    5'd1);
        check("hd_rt",    rt_o,    5'd2);
        check("hd_rd",    rd_o,    5'd3);
        check("hd_shamt", shamt_o, 5'd0);
        check("hd_funct", funct_o, 6'h20);
        for (int i = 0; i < 5; i++) begin
            check("hd_valid", instr_valid_o, 1);
            check("hd_instr", instr_o,       32'h0022_1820);
            if (i < 4) tick();
        end
        flush_i = 1'b1; instr_ready_i = 1'b1; fetch_en_i = 1'b1; pc_i = 32'h28;
        tick();
        flush_i = 1'b0; instr_ready_i = 1'b0; fetch_en_i = 1'b0;
        check("hd_flush_valid", instr_valid_o, 0);
        check("hd_flush_noreq", mem_req_o,     0);
        tick();
        check("hd_adv_count", adv_cnt - base, 1);

        // Misaligned PC -> terminal fault, no request
        base = req_cnt;
        pc_i = 32'h6; fetch_en_i = 1'b1;
        tick();
        check("mis_fault", {fault_o, fault_code_o}, 3'b101);
        check("mis_req",   mem_req_o, 0);
        flush_i = 1'b1; pc_i = 32'h8;
        repeat (3) tick();
        check("mis_sticky",  {fault_o, fault_code_o}, 3'b101);
        check("mis_valid",   instr_valid_o, 0);
        check("mis_req_cnt", req_cnt - base, 0);
        rst_n = 1'b0;
        #1;
        check("mis_rst", {fault_o, fault_code_o}, 0);
        fetch_en_i = 1'b0; flush_i = 1'b0;
        #1;
        rst_n = 1'b1;
        tick();

        // Memory never answers -> timeout fault after 16 BUSY cycles
        pc_i = 32'h40; fetch_en_i = 1'b1;
        tick();
        fetch_en_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("to_busy", {fault_o, mem_req_o}, 2'b01);
            tick();
        end
        check("to_fault", {fault_o, fault_code_o}, 3'b110);
        check("to_req",   mem_req_o, 0);
        repeat (2) tick();
        check("to_sticky", {fault_o, fault_code_o}, 3'b110);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();

        // Asynchronous reset in the middle of a BUSY cycle
        pc_i = 32'h50; fetch_en_i = 1'b1; mem_ack_i = 1'b1; mem_rdata_i = 32'hCAFE_F00D;
        tick();
        tick();
        instr_ready_i = 1'b1; pc_i = 32'h54; mem_ack_i = 1'b0;
        tick();
        instr_ready_i = 1'b0; fetch_en_i = 1'b0;
        check("ar_instr", instr_o,    32'hCAFE_F00D);
        check("ar_req",   mem_req_o,  1);
        check("ar_addr",  mem_addr_o, 32'h54);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_req_rst",   mem_req_o,     0);
        check("ar_addr_rst",  mem_addr_o,    0);
        check("ar_instr_rst", instr_o,       0);
        check("ar_ipc_rst",   instr_pc_o,    0);
        check("ar_valid_rst", instr_valid_o, 0);
        check("ar_fault_rst", {fault_o, fault_code_o, pc_adv_o}, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
